mem_stage: RTL
==============

# mem_stage

Memory-access stage of the five-stage CPU. It sits directly downstream of the execute stage: it consumes the ALU result, store data, `mem_rw` / `is_load` and `func3`, and runs a single-outstanding request/acknowledge transaction on the data-memory port. It also performs byte-lane steering and load sign/zero extension, and registers the outcome toward write-back. It stalls the upstream pipeline while a memory transaction is pending.

## Interface
Parameters:
- `ADDR_W`, default 32: data-memory byte-address width.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: execute stage presents a valid instruction.
- `in_ready`  out  1: stage can accept this cycle.
- `result`  in  64: ALU result; byte address for load/store.
- `store_data`  in  64: rs2 value for stores.
- `mem_rw`  in  1: 1 = store.
- `is_load`  in  1: 1 = load.
- `func3`  in  3: access size/sign.
- `rd`  in  5: destination register.
- `reg_write`  in  1: instruction writes `rd`.
- `dmem_req`  out  1: request to data memory.
- `dmem_we`  out  1: 1 = write.
- `dmem_addr`  out  ADDR_W: 8-byte-aligned address, `{result[ADDR_W-1:3],3'b000}`.
- `dmem_wdata`  out  64: lane-shifted store data.
- `dmem_wstrb`  out  8: byte strobes.
- `dmem_ack`  in  1: memory completes the request this cycle.
- `dmem_rdata`  in  64: read data, valid with `dmem_ack`.
- `wb_valid`  out  1: one-cycle pulse, write-back fields valid.
- `wb_rd`  out  5: destination register.
- `wb_data`  out  64: load data or passed-through `result`.
- `wb_reg_write`  out  1: write-back enable.
- `stall`  out  1: `in_valid & ~in_ready`.
- `misalign`  out  1: misaligned-access flag, pulses with `wb_valid`.

## Operation
- FSM states: IDLE and ACCESS. `in_ready = (state == IDLE)`.
- **Non-memory op** (IDLE, `in_valid`, `mem_rw = 0`, `is_load = 0`):
  - Registered to write-back on the accept edge.
  - `wb_data = result`, `wb_reg_write = reg_write & (rd != 0)`.
  - State remains IDLE.
- **Memory op** (IDLE, `in_valid`, `mem_rw | is_load`):
  - Latch address, size, offset `o = result[2:0]`, store data, `rd` and `reg_write`; go to ACCESS.
  - If both `mem_rw` and `is_load` are set, `mem_rw` wins (store).
- **ACCESS:**
  - `dmem_req = 1`; `dmem_we`, `dmem_addr`, `dmem_wdata` and `dmem_wstrb` are held stable until `dmem_ack`.
  - On `dmem_ack`: go to IDLE and pulse `wb_valid` on the next cycle.
- **Store sizes** (`func3` 000/001/010/011 = SB/SH/SW/SD):
  - Base strobe is 0x01/0x03/0x0F/0xFF.
  - `dmem_wstrb = (base << o)` truncated to 8 bits; `dmem_wdata = store_data << (8*o)`.
  - Stores complete with `wb_reg_write = 0`.
- **Load sizes** (`func3` 000/001/010/011/100/101/110 = LB/LH/LW/LD/LBU/LHU/LWU):
  - Extracted value = `dmem_rdata >> (8*o)`, masked to size.
  - Sign-extended for 000/001/010; zero-extended for 100/101/110.
- **Undefined `func3`** (load 111, store 1xx): treated as 64-bit (LD/SD).
- **Load write-back:** `wb_reg_write = reg_write & (rd != 0)`.

## Timing
- **Reset:** state IDLE. Every output is 0 except `in_ready = 1`: `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_wstrb`, `wb_valid`, `wb_rd`, `wb_data`, `wb_reg_write`, `stall` and `misalign` are all 0.
- **Non-memory op:** accepted at edge T0; `wb_valid = 1` for the cycle after T0. Throughput is one per cycle.
- **Memory op:**
  - Accepted at edge T0; `dmem_req` rises after T0.
  - First `dmem_ack` sampled at edge Tn (n ≥ 1) clears `dmem_req` and sets `wb_valid`, both after Tn. `in_ready` returns to 1 after Tn.
  - Minimum latency is 2 edges from accept to `wb_valid`, so the maximum rate is one memory op per 2 cycles.
- **`dmem_ack` outside ACCESS:** ignored.
- **`wb_valid`:** never high for two consecutive cycles from a single instruction.
- **`rst` during ACCESS:** the transaction is abandoned. `dmem_req` drops after that edge, no `wb_valid` is produced, and a late `dmem_ack` is ignored.
- **Upstream inputs during ACCESS:** ignored. Upstream must hold them because `stall = 1`.

## Configuration
- Macro `MEM_MISALIGN_CHECK_EN`.
- **Defined:**
  - An access is misaligned when: half with `o[0] != 0`, word with `o[1:0] != 0`, or double with `o != 0`.
  - A misaligned access issues no `dmem_req` and completes like a non-memory op in one cycle, with `wb_reg_write = 0` and `misalign = 1` pulsing with `wb_valid`.
- **Not defined:**
  - `misalign` is tied to 0 and every access is issued.
  - Strobes and bytes shifted past lane 7 are discarded, so loads see 0 in the missing upper bytes before extension.

## Test plan
- **Reset:** hold `rst` 2 cycles with `dmem_ack = 1` -> all outputs 0, `in_ready = 1`, and no `wb_valid` afterward.
- **ALU pass-through:** `result = 0x1234`, `rd = 5`, `reg_write = 1` -> `wb_valid` the next cycle with `wb_data = 0x1234`, `wb_rd = 5`, `wb_reg_write = 1`. Back-to-back ops produce consecutive `wb_valid`.
- **SB:** `result = 0x1003`, `store_data = 0xAB`, `func3 = 000`, `dmem_ack` after 3 wait cycles -> `dmem_addr = 0x1000`, `dmem_wstrb = 0x08`, `dmem_wdata[31:24] = 0xAB` held stable 3 cycles, `stall = 1` throughout, `wb_reg_write = 0`.
- **LH / LHU:** `result = 0x2006`, `dmem_rdata = 0x8001_0000_0000_0000` -> LH (001) gives `wb_data = 0xFFFF_FFFF_FFFF_8001`; LHU (101) gives `0x8001`.
- **Reset mid-access:** assert `rst` in the second ACCESS cycle, then `dmem_ack` -> `dmem_req` drops after the reset edge and no `wb_valid` is produced.
- **Misaligned LW:** `result = 0x3002`, `func3 = 010` -> with `MEM_MISALIGN_CHECK_EN`: no `dmem_req`, `misalign = 1`, `wb_reg_write = 0` the next cycle. Without the macro: `dmem_wstrb` is irrelevant, and the load reads lanes 2–5 from `dmem_addr = 0x3000`.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory port bundle for mem_stage: single-outstanding request/acknowledge
// bus. The master side issues requests, the slave side answers with ack/rdata.
interface mem_stage_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [63:0]       dmem_wdata;
    logic [7:0]        dmem_wstrb;
    logic              dmem_ack;
    logic [63:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: runs one request/ack transaction per load/store on the
// data-memory port, steers byte lanes, sign/zero-extends loads and registers
// the outcome toward write-back. Non-memory ops pass straight through.
// Optional build macro MEM_MISALIGN_CHECK_EN: when defined, misaligned
// half/word/double accesses are not issued and complete at once with the
// misalign flag set; when undefined every access is issued.
module mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] result,
    input  logic [63:0] store_data,
    input  logic        mem_rw,
    input  logic        is_load,
    input  logic [2:0]  func3,
    input  logic [4:0]  rd,
    input  logic        reg_write,
    mem_stage_if.master dmem,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    output logic        wb_reg_write,
    output logic        stall,
    output logic        misalign
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    // Access size code: 0 byte, 1 half, 2 word, 3 double. Undefined encodings
    // (store 1xx, load 111) fall back to a double-word access.
    function automatic logic [1:0] size_code(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return f3[2] ? 2'd3 : f3[1:0];
        else
            return (f3 == 3'b111) ? 2'd3 : f3[1:0];
    endfunction

    // Byte strobes for the access; lanes shifted past lane 7 are dropped.
    function automatic logic [7:0] lane_strobe(input logic [1:0] sz, input logic [2:0] off);
        logic [7:0] base;
        case (sz)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    // Pull the addressed bytes down to lane 0 and extend to 64 bits.
    function automatic logic [63:0] load_extend(input logic [63:0] rdata,
                                                input logic [2:0]  off,
                                                input logic [2:0]  f3);
        logic [63:0] sh;
        logic [63:0] ext;
        sh = rdata >> {off, 3'b000};
        case (size_code(1'b0, f3))
            2'd0:    ext = f3[2] ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            2'd1:    ext = f3[2] ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            2'd2:    ext = f3[2] ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: ext = sh;
        endcase
        return ext;
    endfunction

`ifdef MEM_MISALIGN_CHECK_EN
    // Natural alignment check: offset must be a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] off);
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return off[0];
            2'd2:    return off[1:0] != 2'b00;
            default: return off != 3'b000;
        endcase
    endfunction
`endif

    logic [0:0]        state_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic              we_p0;
    logic [2:0]        off_p0;
    logic [2:0]        f3_p0;
    logic [63:0]       wdata_p0;
    logic [7:0]        wstrb_p0;
    logic [4:0]        rd_p0;
    logic              rw_p0;

    logic              vld_p1;
    logic [63:0]       wb_data_p1;
    logic [4:0]        wb_rd_p1;
    logic              wb_rw_p1;

    logic              mem_op;
    logic [1:0]        acc_size;
    logic              mis_now;
    logic              accept;
    logic              issue;
    logic              finish_now;
    logic              ack_now;

    assign mem_op   = mem_rw | is_load;
    assign acc_size = size_code(mem_rw, func3);
`ifdef MEM_MISALIGN_CHECK_EN
    assign mis_now  = mem_op & is_misaligned(acc_size, result[2:0]);
`else
    assign mis_now  = 1'b0;
`endif
    assign accept     = in_valid & (state_p0 == IDLE);
    assign issue      = accept & mem_op & ~mis_now;
    assign finish_now = accept & ~issue;
    assign ack_now    = (state_p0 == ACCESS) & dmem.dmem_ack;

    // ---- stage p0: accept / memory transaction ----

`ifdef MEM_MISALIGN_CHECK_EN
    logic mis_p1;

    // Misalign flag pulses together with the write-back valid.
    always_ff @(posedge clk) begin
        if (rst) mis_p1 <= 1'b0;
        else     mis_p1 <= finish_now & mis_now;
    end

    assign misalign = mis_p1;
`else
    assign misalign = 1'b0;
`endif

    // Control: IDLE/ACCESS sequencing and the one-cycle write-back pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= IDLE;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= finish_now | ack_now;
            if (issue)
                state_p0 <= ACCESS;
            else if (ack_now)
                state_p0 <= IDLE;
        end
    end

    // Request fields latched at accept and held for the whole transaction.
    always_ff @(posedge clk) begin
        if (issue) begin
            addr_p0  <= {result[ADDR_W-1:3], 3'b000};
            we_p0    <= mem_rw;
            off_p0   <= result[2:0];
            f3_p0    <= func3;
            wdata_p0 <= store_data << {result[2:0], 3'b000};
            wstrb_p0 <= lane_strobe(acc_size, result[2:0]);
            rd_p0    <= rd;
            rw_p0    <= reg_write & (rd != 5'd0);
        end
    end

    // ---- stage p1: write-back register ----

    // Write-back payload from either an immediate completion or the memory ack.
    always_ff @(posedge clk) begin
        if (finish_now) begin
            wb_data_p1 <= result;
            wb_rd_p1   <= rd;
            wb_rw_p1   <= reg_write & (rd != 5'd0) & ~mem_op;
        end else if (ack_now) begin
            wb_data_p1 <= we_p0 ? 64'd0 : load_extend(dmem.dmem_rdata, off_p0, f3_p0);
            wb_rd_p1   <= rd_p0;
            wb_rw_p1   <= ~we_p0 & rw_p0;
        end
    end

    // Data outputs are gated by their qualifiers so idle/reset values read 0.
    assign in_ready        = (state_p0 == IDLE);
    assign stall           = in_valid & ~in_ready;
    assign dmem.dmem_req   = (state_p0 == ACCESS);
    assign dmem.dmem_we    = dmem.dmem_req & we_p0;
    assign dmem.dmem_addr  = dmem.dmem_req ? addr_p0  : '0;
    assign dmem.dmem_wdata = dmem.dmem_req ? wdata_p0 : 64'd0;
    assign dmem.dmem_wstrb = dmem.dmem_req ? wstrb_p0 : 8'd0;
    assign wb_valid        = vld_p1;
    assign wb_rd           = vld_p1 ? wb_rd_p1   : 5'd0;
    assign wb_data         = vld_p1 ? wb_data_p1 : 64'd0;
    assign wb_reg_write    = vld_p1 & wb_rw_p1;
endmodule
